sram_ctrl: RTL and testbench

- Bridges the 68k-side 16-bit bus (as/rw/uds/lds, dtack handshake) to the board's 32-bit asynchronous SRAM, built from two 16-bit chips sharing ram_addr.
- Sits between the CPU bus decode and the SRAM pins of top; the board-level memory models hang directly off its outputs.
- Generates multi-cycle SRAM timing: setup, strobe, hold.
- Acknowledges with dtack.

---
 rtl/m68k_bus_pkg.sv | 32 +++
 rtl/sram_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared 68k bus / SRAM bridge types: FSM encoding, rw and chip-index constants, select decode.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        ACK    = 3'd4
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Chip 1 holds data[31:16] (the even 16-bit word), chip 0 holds data[15:0].
    localparam logic CHIP_HI = 1'b1;
    localparam logic CHIP_LO = 1'b0;

    // Big-endian word placement: byte address bit 1 clear lands in the high chip.
    function automatic logic addr_to_chip(input logic a1);
        return a1 ? CHIP_LO : CHIP_HI;
    endfunction

    // Active-low per-chip strobe pair; bit index equals chip index.
    // The unselected chip always sees 1; the selected chip sees ~en.
    function automatic logic [1:0] chip_sel_n(input logic chip, input logic en);
        return (chip == CHIP_HI) ? {~en, 1'b1} : {1'b1, ~en};
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Bridges the 68k 16-bit bus (as/rw/uds/lds, dtack) to a 32-bit async SRAM built from two 16-bit chips.
// Latency: dtack rises WAIT_CYCLES+3 edges after as is sampled (edge 1 when no byte is selected).
// Backpressure: the CPU waits on dtack; a new access needs as to drop first, and an early drop still completes the SRAM cycle.
module sram_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                as,
    input  logic                rw,
    input  logic                uds,
    input  logic                lds,
    input  logic [ADDR_W+1:0]   addr,
    input  logic [15:0]         data_write,
    output logic [15:0]         data_read,
    output logic                dtack,
    output logic [ADDR_W-1:0]   ram_addr,
    inout  wire  [31:0]         ram_data,
    output logic [1:0]          ram_ce_n,
    output logic [1:0]          ram_ub_n,
    output logic [1:0]          ram_lb_n,
    output logic                ram_we_n,
    output logic                ram_oe_n
);

    localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              lat_rw;
    logic              lat_uds;
    logic              lat_lds;
    logic              lat_chip;
    logic [15:0]       wr_dat;
    logic              drive_en;
    logic [15:0]       rd_half;
    logic [15:0]       rd_masked;
    logic              addr_unused;

    // Byte address bit 0 carries no information on a 16-bit bus.
    assign addr_unused = addr[0];

    // Both halves carry the write word; only the selected chip has ce_n low, so the other half is inert.
    assign ram_data = drive_en ? {wr_dat, wr_dat} : {32{1'bz}};

    // Pick the half belonging to the latched chip and zero the lanes the CPU did not select.
    always_comb begin
        rd_half   = (lat_chip == CHIP_HI) ? ram_data[31:16] : ram_data[15:0];
        rd_masked = {lat_uds ? rd_half[15:8] : 8'h00, lat_lds ? rd_half[7:0] : 8'h00};
    end

    // Transfer FSM: all SRAM strobes and dtack are registered so the pins are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_rw    <= RW_READ;
            lat_uds   <= 1'b0;
            lat_lds   <= 1'b0;
            lat_chip  <= CHIP_HI;
            wr_dat    <= 16'h0000;
            drive_en  <= 1'b0;
            data_read <= 16'h0000;
            dtack     <= 1'b0;
            ram_addr  <= '0;
            ram_ce_n  <= 2'b11;
            ram_ub_n  <= 2'b11;
            ram_lb_n  <= 2'b11;
            ram_we_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (as) begin
                        if (uds || lds) begin
                            lat_rw   <= rw;
                            lat_uds  <= uds;
                            lat_lds  <= lds;
                            lat_chip <= addr_to_chip(addr[1]);
                            wr_dat   <= data_write;
                            drive_en <= (rw == RW_WRITE);
                            ram_addr <= addr[ADDR_W+1:2];
                            ram_ce_n <= chip_sel_n(addr_to_chip(addr[1]), 1'b1);
                            ram_ub_n <= chip_sel_n(addr_to_chip(addr[1]), uds);
                            ram_lb_n <= chip_sel_n(addr_to_chip(addr[1]), lds);
                            state    <= SETUP;
                        end else begin
                            // Nothing to transfer: acknowledge without touching the SRAM.
                            state <= ACK;
                        end
                    end
                end
                SETUP: begin
                    wait_cnt <= '0;
                    if (lat_rw == RW_READ) begin
                        ram_oe_n <= 1'b0;
                    end else begin
                        ram_we_n <= 1'b0;
                    end
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt == CNT_LAST) begin
                        ram_oe_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        if (lat_rw == RW_READ) begin
                            data_read <= rd_masked;
                        end
                        state <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // Write data stays on the bus through HOLD and is released with the selects.
                    ram_ce_n <= 2'b11;
                    ram_ub_n <= 2'b11;
                    ram_lb_n <= 2'b11;
                    drive_en <= 1'b0;
                    state    <= ACK;
                end
                ACK: begin
                    // dtack follows as; an early-dropped as means dtack is never raised.
                    dtack <= as;
                    if (!as) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        as;
    logic        rw;
    logic        uds;
    logic        lds;
    logic [19:0] addr;
    logic [15:0] data_write;

    // Main instance, WAIT_CYCLES = 2, with SRAM model attached.
    wire  [31:0] ram_data;
    logic [15:0] data_read;
    logic        dtack;
    logic [17:0] ram_addr;
    logic [1:0]  ram_ce_n, ram_ub_n, ram_lb_n;
    logic        ram_we_n, ram_oe_n;

    // Latency-only instances, WAIT_CYCLES = 1 and 4.
    wire  [31:0] rd_w1, rd_w4;
    logic [15:0] dr_w1, dr_w4;
    logic        dt_w1, dt_w4;
    logic [17:0] ra_w1, ra_w4;
    logic [1:0]  ce_w1, ub_w1, lb_w1, ce_w4, ub_w4, lb_w4;
    logic        we_w1, oe_w1, we_w4, oe_w4;

    sram_ctrl #(.ADDR_W(18), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .as(as), .rw(rw), .uds(uds), .lds(lds),
        .addr(addr), .data_write(data_write), .data_read(data_read), .dtack(dtack),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_ce_n(ram_ce_n),
        .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
    );

    sram_ctrl #(.ADDR_W(18), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(reset), .as(as), .rw(rw), .uds(uds), .lds(lds),
        .addr(addr), .data_write(data_write), .data_read(dr_w1), .dtack(dt_w1),
        .ram_addr(ra_w1), .ram_data(rd_w1), .ram_ce_n(ce_w1),
        .ram_ub_n(ub_w1), .ram_lb_n(lb_w1), .ram_we_n(we_w1), .ram_oe_n(oe_w1)
    );

    sram_ctrl #(.ADDR_W(18), .WAIT_CYCLES(4)) dut_w4 (
        .clk(clk), .reset(reset), .as(as), .rw(rw), .uds(uds), .lds(lds),
        .addr(addr), .data_write(data_write), .data_read(dr_w4), .dtack(dt_w4),
        .ram_addr(ra_w4), .ram_data(rd_w4), .ram_ce_n(ce_w4),
        .ram_ub_n(ub_w4), .ram_lb_n(lb_w4), .ram_we_n(we_w4), .ram_oe_n(oe_w4)
    );

    always #5 clk = ~clk;

    // Two 16-bit async SRAM chips; writes are taken on clock edges where we_n is low.
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem0 [0:262143];
    logic [15:0] m1_word, m0_word;

    always_comb begin
        m1_word = mem1[ram_addr];
        m0_word = mem0[ram_addr];
    end

    assign ram_data[31:24] = (!ram_ce_n[1] && !ram_ub_n[1] && !ram_oe_n) ? m1_word[15:8] : 8'hzz;
    assign ram_data[23:16] = (!ram_ce_n[1] && !ram_lb_n[1] && !ram_oe_n) ? m1_word[7:0]  : 8'hzz;
    assign ram_data[15:8]  = (!ram_ce_n[0] && !ram_ub_n[0] && !ram_oe_n) ? m0_word[15:8] : 8'hzz;
    assign ram_data[7:0]   = (!ram_ce_n[0] && !ram_lb_n[0] && !ram_oe_n) ? m0_word[7:0]  : 8'hzz;

    always @(posedge clk) begin
        if (!ram_we_n) begin
            if (!ram_ce_n[1] && !ram_ub_n[1]) mem1[ram_addr][15:8] <= ram_data[31:24];
            if (!ram_ce_n[1] && !ram_lb_n[1]) mem1[ram_addr][7:0]  <= ram_data[23:16];
            if (!ram_ce_n[0] && !ram_ub_n[0]) mem0[ram_addr][15:8] <= ram_data[15:8];
            if (!ram_ce_n[0] && !ram_lb_n[0]) mem0[ram_addr][7:0]  <= ram_data[7:0];
        end
    end

    // Probe driver: reads back a known pattern only if the DUT has released the bus.
    logic probe_en = 1'b0;
    assign ram_data = probe_en ? 32'hA5A5_5A5A : {32{1'bz}};

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-transaction observations.
    int          lat0, lat1, lat4;
    int          we_cnt, oe_cnt;
    logic [1:0]  ce_s, ub_s, lb_s;
    logic [17:0] addr_s;
    logic [31:0] wbus_s;
    bit          dtack_ever, hold_bad, ce_touched;
    logic        dtack_after_drop;

    task sample(input int i);
        if (dtack === 1'b1 && lat0 < 0) lat0 = i;
        if (dt_w1 === 1'b1 && lat1 < 0) lat1 = i;
        if (dt_w4 === 1'b1 && lat4 < 0) lat4 = i;
        if (dtack === 1'b1) dtack_ever = 1'b1;
        if (ram_we_n === 1'b0) begin
            we_cnt++;
            wbus_s = ram_data;
        end
        if (ram_oe_n === 1'b0) oe_cnt++;
        if (ram_ce_n !== 2'b11) ce_touched = 1'b1;
        if (i == 0) begin
            ce_s   = ram_ce_n;
            ub_s   = ram_ub_n;
            lb_s   = ram_lb_n;
            addr_s = ram_addr;
        end
    endtask

    // One bus cycle; the posedge after as is first driven is edge 0.
    task run_access(input logic r, input logic u, input logic l, input logic [19:0] a,
                    input logic [15:0] wd, input int drop_at, input int hold_cycles);
        @(negedge clk);
        rw = r; uds = u; lds = l; addr = a; data_write = wd; as = 1'b1;
        lat0 = -1; lat1 = -1; lat4 = -1; we_cnt = 0; oe_cnt = 0;
        dtack_ever = 1'b0; hold_bad = 1'b0; ce_touched = 1'b0; wbus_s = 32'h0;
        dtack_after_drop = 1'bx;
        if (drop_at >= 0) begin
            for (int i = 0; i < 16; i++) begin
                @(posedge clk); #1;
                sample(i);
                if (i == drop_at) as = 1'b0;
            end
        end else begin
            for (int i = 0; i < 40 && !(lat0 >= 0 && lat1 >= 0 && lat4 >= 0); i++) begin
                @(posedge clk); #1;
                sample(i);
            end
            for (int i = 0; i < hold_cycles; i++) begin
                @(posedge clk); #1;
                if (dtack !== 1'b1 || ram_ce_n !== 2'b11 || ram_oe_n !== 1'b1 || ram_we_n !== 1'b1)
                    hold_bad = 1'b1;
                sample(100 + i);
            end
            as = 1'b0;
            @(posedge clk); #1;
            dtack_after_drop = dtack;
        end
        repeat (6) @(posedge clk);
    endtask

    task test_reset;
        reset = 1'b1; as = 1'b0; rw = 1'b1; uds = 1'b0; lds = 1'b0; addr = 20'h0; data_write = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ram_ce_n !== 2'b11) begin n_fail++; $display("FAIL rst_ce_n: got %b want 11", ram_ce_n); end
        n_cmp++; if (ram_ub_n !== 2'b11) begin n_fail++; $display("FAIL rst_ub_n: got %b want 11", ram_ub_n); end
        n_cmp++; if (ram_lb_n !== 2'b11) begin n_fail++; $display("FAIL rst_lb_n: got %b want 11", ram_lb_n); end
        n_cmp++; if (ram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b want 1", ram_we_n); end
        n_cmp++; if (ram_oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n: got %b want 1", ram_oe_n); end
        n_cmp++; if (ram_addr !== 18'h0) begin n_fail++; $display("FAIL rst_ram_addr: got %h want 0", ram_addr); end
        n_cmp++; if (data_read !== 16'h0) begin n_fail++; $display("FAIL rst_data_read: got %h want 0", data_read); end
        n_cmp++; if (dtack !== 1'b0) begin n_fail++; $display("FAIL rst_dtack: got %b want 0", dtack); end
        probe_en = 1'b1; #1;
        n_cmp++; if (ram_data !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL rst_bus_released: got %h want a5a55a5a", ram_data); end
        probe_en = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task test_write_hi;
        run_access(1'b0, 1'b1, 1'b1, 20'h00000, 16'h1234, -1, 0);
        n_cmp++; if (ce_s !== 2'b01) begin n_fail++; $display("FAIL wr_hi_ce_n: got %b want 01", ce_s); end
        n_cmp++; if (ub_s !== 2'b01) begin n_fail++; $display("FAIL wr_hi_ub_n: got %b want 01", ub_s); end
        n_cmp++; if (lb_s !== 2'b01) begin n_fail++; $display("FAIL wr_hi_lb_n: got %b want 01", lb_s); end
        n_cmp++; if (wbus_s[31:16] !== 16'h1234) begin n_fail++; $display("FAIL wr_hi_bus: got %h want 1234", wbus_s[31:16]); end
        n_cmp++; if (we_cnt !== 2) begin n_fail++; $display("FAIL wr_hi_we_cycles: got %0d want 2", we_cnt); end
        n_cmp++; if (oe_cnt !== 0) begin n_fail++; $display("FAIL wr_hi_oe_cycles: got %0d want 0", oe_cnt); end
        n_cmp++; if (lat0 !== 5) begin n_fail++; $display("FAIL wr_hi_latency: got %0d want 5", lat0); end
        n_cmp++; if (dtack_after_drop !== 1'b0) begin n_fail++; $display("FAIL wr_hi_dtack_release: got %b want 0", dtack_after_drop); end
    endtask

    task test_write_read_lo;
        run_access(1'b0, 1'b1, 1'b1, 20'h00002, 16'hABCD, -1, 0);
        n_cmp++; if (ce_s !== 2'b10) begin n_fail++; $display("FAIL wr_lo_ce_n: got %b want 10", ce_s); end
        n_cmp++; if (addr_s !== 18'h0) begin n_fail++; $display("FAIL wr_lo_addr: got %h want 0", addr_s); end
        run_access(1'b1, 1'b1, 1'b1, 20'h00002, 16'h0000, -1, 0);
        n_cmp++; if (ce_s !== 2'b10) begin n_fail++; $display("FAIL rd_lo_ce_n: got %b want 10", ce_s); end
        n_cmp++; if (oe_cnt !== 2) begin n_fail++; $display("FAIL rd_lo_oe_cycles: got %0d want 2", oe_cnt); end
        n_cmp++; if (we_cnt !== 0) begin n_fail++; $display("FAIL rd_lo_we_cycles: got %0d want 0", we_cnt); end
        n_cmp++; if (data_read !== 16'hABCD) begin n_fail++; $display("FAIL rd_lo_data: got %h want abcd", data_read); end
        n_cmp++; if (lat0 !== 5) begin n_fail++; $display("FAIL rd_lo_latency: got %0d want 5", lat0); end
        run_access(1'b1, 1'b1, 1'b1, 20'h00000, 16'h0000, -1, 0);
        n_cmp++; if (data_read !== 16'h1234) begin n_fail++; $display("FAIL rd_hi_data: got %h want 1234", data_read); end
    endtask

    task test_byte_lanes;
        run_access(1'b0, 1'b1, 1'b0, 20'h00000, 16'h56FF, -1, 0);
        n_cmp++; if (ub_s !== 2'b01) begin n_fail++; $display("FAIL byte_wr_ub_n: got %b want 01", ub_s); end
        n_cmp++; if (lb_s !== 2'b11) begin n_fail++; $display("FAIL byte_wr_lb_n: got %b want 11", lb_s); end
        run_access(1'b1, 1'b1, 1'b1, 20'h00000, 16'h0000, -1, 0);
        n_cmp++; if (data_read !== 16'h5634) begin n_fail++; $display("FAIL byte_rd_word: got %h want 5634", data_read); end
        run_access(1'b1, 1'b0, 1'b1, 20'h00000, 16'h0000, -1, 0);
        n_cmp++; if (data_read !== 16'h0034) begin n_fail++; $display("FAIL byte_rd_lds: got %h want 0034", data_read); end
    endtask

    task test_top_addr;
        run_access(1'b0, 1'b1, 1'b1, 20'hFFFFE, 16'hBEEF, -1, 0);
        n_cmp++; if (addr_s !== 18'h3FFFF) begin n_fail++; $display("FAIL top_ram_addr: got %h want 3ffff", addr_s); end
        n_cmp++; if (ce_s !== 2'b10) begin n_fail++; $display("FAIL top_ce_n: got %b want 10", ce_s); end
        n_cmp++; if (lat0 !== 5) begin n_fail++; $display("FAIL top_latency_w2: got %0d want 5", lat0); end
        n_cmp++; if (lat1 !== 4) begin n_fail++; $display("FAIL top_latency_w1: got %0d want 4", lat1); end
        n_cmp++; if (lat4 !== 7) begin n_fail++; $display("FAIL top_latency_w4: got %0d want 7", lat4); end
        run_access(1'b1, 1'b1, 1'b1, 20'hFFFFE, 16'h0000, -1, 0);
        n_cmp++; if (data_read !== 16'hBEEF) begin n_fail++; $display("FAIL top_rd_data: got %h want beef", data_read); end
    endtask

    task test_held_as;
        run_access(1'b1, 1'b1, 1'b1, 20'h00002, 16'h0000, -1, 10);
        n_cmp++; if (hold_bad !== 1'b0) begin n_fail++; $display("FAIL held_as_quiet: got %b want 0", hold_bad); end
        n_cmp++; if (oe_cnt !== 2) begin n_fail++; $display("FAIL held_as_oe_cycles: got %0d want 2", oe_cnt); end
        n_cmp++; if (data_read !== 16'hABCD) begin n_fail++; $display("FAIL held_as_data: got %h want abcd", data_read); end
        n_cmp++; if (dtack_after_drop !== 1'b0) begin n_fail++; $display("FAIL held_as_release: got %b want 0", dtack_after_drop); end
    endtask

    task test_drop_early;
        run_access(1'b0, 1'b1, 1'b1, 20'h00004, 16'h7777, 2, 0);
        n_cmp++; if (dtack_ever !== 1'b0) begin n_fail++; $display("FAIL drop_dtack_seen: got %b want 0", dtack_ever); end
        n_cmp++; if (we_cnt !== 2) begin n_fail++; $display("FAIL drop_we_cycles: got %0d want 2", we_cnt); end
        n_cmp++; if (ram_ce_n !== 2'b11) begin n_fail++; $display("FAIL drop_ce_idle: got %b want 11", ram_ce_n); end
        n_cmp++; if (dtack !== 1'b0) begin n_fail++; $display("FAIL drop_dtack_idle: got %b want 0", dtack); end
        run_access(1'b1, 1'b1, 1'b1, 20'h00004, 16'h0000, -1, 0);
        n_cmp++; if (data_read !== 16'h7777) begin n_fail++; $display("FAIL drop_readback: got %h want 7777", data_read); end
    endtask

    task test_no_select;
        run_access(1'b1, 1'b0, 1'b0, 20'h00002, 16'h0000, -1, 0);
        n_cmp++; if (lat0 !== 1) begin n_fail++; $display("FAIL nosel_latency_w2: got %0d want 1", lat0); end
        n_cmp++; if (lat1 !== 1) begin n_fail++; $display("FAIL nosel_latency_w1: got %0d want 1", lat1); end
        n_cmp++; if (lat4 !== 1) begin n_fail++; $display("FAIL nosel_latency_w4: got %0d want 1", lat4); end
        n_cmp++; if (ce_touched !== 1'b0) begin n_fail++; $display("FAIL nosel_ce_touched: got %b want 0", ce_touched); end
        n_cmp++; if (dtack_after_drop !== 1'b0) begin n_fail++; $display("FAIL nosel_release: got %b want 0", dtack_after_drop); end
        n_cmp++; if (data_read !== 16'h7777) begin n_fail++; $display("FAIL nosel_data_hold: got %h want 7777", data_read); end
    endtask

    task test_reset_mid;
        @(negedge clk);
        rw = 1'b0; uds = 1'b1; lds = 1'b1; addr = 20'h00008; data_write = 16'hFFFF; as = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ram_we_n !== 1'b0) begin n_fail++; $display("FAIL midrst_in_access: got %b want 0", ram_we_n); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ram_we_n !== 1'b1) begin n_fail++; $display("FAIL midrst_we_n: got %b want 1", ram_we_n); end
        n_cmp++; if (ram_oe_n !== 1'b1) begin n_fail++; $display("FAIL midrst_oe_n: got %b want 1", ram_oe_n); end
        n_cmp++; if (ram_ce_n !== 2'b11) begin n_fail++; $display("FAIL midrst_ce_n: got %b want 11", ram_ce_n); end
        n_cmp++; if (dtack !== 1'b0) begin n_fail++; $display("FAIL midrst_dtack: got %b want 0", dtack); end
        probe_en = 1'b1; #1;
        n_cmp++; if (ram_data !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL midrst_bus_released: got %h want a5a55a5a", ram_data); end
        probe_en = 1'b0;
        @(negedge clk); reset = 1'b0; as = 1'b0;
        repeat (8) @(posedge clk);
        run_access(1'b1, 1'b1, 1'b1, 20'h00000, 16'h0000, -1, 0);
        n_cmp++; if (data_read !== 16'h5634) begin n_fail++; $display("FAIL midrst_readback: got %h want 5634", data_read); end
        n_cmp++; if (lat0 !== 5) begin n_fail++; $display("FAIL midrst_latency: got %0d want 5", lat0); end
    endtask

    initial begin
        test_reset();
        test_write_hi();
        test_write_read_lo();
        test_byte_lanes();
        test_top_addr();
        test_held_as();
        test_drop_early();
        test_no_select();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
